alt_ddrx_ecc_scrub_ctrl: RTL and testbench

ECC error-handling controller for the DDRX controller read path. It consumes the per-beat status of the ECC decoder (corrected / detected / fatal), aligns it with the beat address, and keeps statistics and a sticky interrupt. For single-bit (corrected) errors, it schedules a write-back of the corrected word through a req/ack handshake to the command arbiter.

---
 rtl/alt_ddrx_ecc_pkg.sv | 17 +
 rtl/alt_ddrx_sat_counter.sv | 25 ++
 rtl/alt_ddrx_ecc_scrub_ctrl.sv | 151 +++++++++++++++
 tb/tb_alt_ddrx_ecc_scrub_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_ddrx_ecc_pkg.sv
// Shared types and helpers for the DDRX ECC scrub controller.
// Holds the scrub FSM encoding and the saturating increment used by the statistics counters.
package alt_ddrx_ecc_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } scrub_state_t;

  // Saturating increment on a value of the given width (at most 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value == max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/alt_ddrx_sat_counter.sv
// Saturating event counter with a synchronous clear.
// A clear coinciding with an increment leaves the count at 1.
module alt_ddrx_sat_counter
  import alt_ddrx_ecc_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_WIDTH'(1) : '0;
    end else if (inc) begin
      count <= CNT_WIDTH'(sat_inc(32'(count), CNT_WIDTH));
    end
  end

endmodule

// File: rtl/alt_ddrx_ecc_scrub_ctrl.sv
// ECC error handler for the DDRX read path: aligns decoder status with the beat address,
// keeps statistics and a sticky interrupt, and schedules write-back of corrected words.
module alt_ddrx_ecc_scrub_ctrl
  import alt_ddrx_ecc_pkg::*;
#(
  parameter int LOCAL_ADDR_WIDTH = 24,
  parameter int DATA_WIDTH       = 64,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                        ctl_clk,
  input  logic                        ctl_reset_n,
  input  logic                        cfg_enable_ecc,
  input  logic                        cfg_enable_auto_corr,
  input  logic                        cfg_clr_intr,
  input  logic                        cfg_clr_cnt,
  input  logic                        rdata_valid,
  input  logic [LOCAL_ADDR_WIDTH-1:0] rdata_addr,
  input  logic                        dec_err_corrected,
  input  logic                        dec_err_detected,
  input  logic                        dec_err_fatal,
  input  logic [DATA_WIDTH-1:0]       dec_data,
  output logic                        scrub_req,
  output logic [LOCAL_ADDR_WIDTH-1:0] scrub_addr,
  output logic [DATA_WIDTH-1:0]       scrub_data,
  input  logic                        scrub_ack,
  output logic                        ecc_interrupt,
  output logic [LOCAL_ADDR_WIDTH-1:0] err_addr,
  output logic                        err_addr_fatal,
  output logic [CNT_WIDTH-1:0]        corr_err_count,
  output logic [CNT_WIDTH-1:0]        fatal_err_count,
  output logic [CNT_WIDTH-1:0]        scrub_drop_count
);

  logic                        v1;
  logic [LOCAL_ADDR_WIDTH-1:0] addr1;
  logic                        captured;
  scrub_state_t                state;

  logic qual, ev_c, ev_f, ev_d, scrub_load, drop_inc;

  // Delay the beat by one cycle so it lines up with the decoder status.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      v1    <= 1'b0;
      addr1 <= '0;
    end else begin
      v1    <= rdata_valid;
      addr1 <= rdata_addr;
    end
  end

  // Fatal takes precedence if the decoder ever flags both.
  assign qual       = v1 & cfg_enable_ecc;
  assign ev_f       = qual & dec_err_fatal;
  assign ev_c       = qual & dec_err_corrected & ~dec_err_fatal;
  assign ev_d       = qual & dec_err_detected;
  assign scrub_load = ev_c & cfg_enable_auto_corr;
  assign drop_inc   = (state == S_REQ) & ~scrub_ack & scrub_load;

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      ecc_interrupt <= 1'b0;
    end else if (ev_d) begin
      ecc_interrupt <= 1'b1;
    end else if (cfg_clr_intr) begin
      ecc_interrupt <= 1'b0;
    end
  end

  // A clear in the same cycle as an event re-arms first, so the event is still captured.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      err_addr       <= '0;
      err_addr_fatal <= 1'b0;
      captured       <= 1'b0;
    end else if (ev_f && (cfg_clr_intr || !err_addr_fatal)) begin
      err_addr       <= addr1;
      err_addr_fatal <= 1'b1;
      captured       <= 1'b1;
    end else if (ev_c && (cfg_clr_intr || !captured)) begin
      err_addr       <= addr1;
      err_addr_fatal <= 1'b0;
      captured       <= 1'b1;
    end else if (cfg_clr_intr) begin
      err_addr       <= '0;
      err_addr_fatal <= 1'b0;
      captured       <= 1'b0;
    end
  end

  // Once raised, a request is held until acknowledged regardless of the enables.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state      <= S_IDLE;
      scrub_req  <= 1'b0;
      scrub_addr <= '0;
      scrub_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (scrub_load) begin
            scrub_addr <= addr1;
            scrub_data <= dec_data;
            scrub_req  <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (scrub_ack) begin
            if (scrub_load) begin
              scrub_addr <= addr1;
              scrub_data <= dec_data;
            end else begin
              scrub_req <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
        default: begin
          scrub_req <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  alt_ddrx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_corr_cnt (
    .clk   (ctl_clk),
    .rst_n (ctl_reset_n),
    .clr   (cfg_clr_cnt),
    .inc   (ev_c),
    .count (corr_err_count)
  );

  alt_ddrx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fatal_cnt (
    .clk   (ctl_clk),
    .rst_n (ctl_reset_n),
    .clr   (cfg_clr_cnt),
    .inc   (ev_f),
    .count (fatal_err_count)
  );

  alt_ddrx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (ctl_clk),
    .rst_n (ctl_reset_n),
    .clr   (cfg_clr_cnt),
    .inc   (drop_inc),
    .count (scrub_drop_count)
  );

endmodule

// File: tb/tb_alt_ddrx_ecc_scrub_ctrl.sv
// Directed bench for the ECC scrub controller: a table of single-beat vectors
// followed by hand-written multi-cycle sequences.
module tb_alt_ddrx_ecc_scrub_ctrl;

  localparam int AW = 24;
  localparam int DW = 64;
  localparam int CW = 8;

  logic          ctl_clk;
  logic          ctl_reset_n;
  logic          cfg_enable_ecc;
  logic          cfg_enable_auto_corr;
  logic          cfg_clr_intr;
  logic          cfg_clr_cnt;
  logic          rdata_valid;
  logic [AW-1:0] rdata_addr;
  logic          dec_err_corrected;
  logic          dec_err_detected;
  logic          dec_err_fatal;
  logic [DW-1:0] dec_data;
  logic          scrub_req;
  logic [AW-1:0] scrub_addr;
  logic [DW-1:0] scrub_data;
  logic          scrub_ack;
  logic          ecc_interrupt;
  logic [AW-1:0] err_addr;
  logic          err_addr_fatal;
  logic [CW-1:0] corr_err_count;
  logic [CW-1:0] fatal_err_count;
  logic [CW-1:0] scrub_drop_count;

  int total = 0;
  int bad   = 0;

  alt_ddrx_ecc_scrub_ctrl #(
    .LOCAL_ADDR_WIDTH (AW),
    .DATA_WIDTH       (DW),
    .CNT_WIDTH        (CW)
  ) dut (
    .ctl_clk              (ctl_clk),
    .ctl_reset_n          (ctl_reset_n),
    .cfg_enable_ecc       (cfg_enable_ecc),
    .cfg_enable_auto_corr (cfg_enable_auto_corr),
    .cfg_clr_intr         (cfg_clr_intr),
    .cfg_clr_cnt          (cfg_clr_cnt),
    .rdata_valid          (rdata_valid),
    .rdata_addr           (rdata_addr),
    .dec_err_corrected    (dec_err_corrected),
    .dec_err_detected     (dec_err_detected),
    .dec_err_fatal        (dec_err_fatal),
    .dec_data             (dec_data),
    .scrub_req            (scrub_req),
    .scrub_addr           (scrub_addr),
    .scrub_data           (scrub_data),
    .scrub_ack            (scrub_ack),
    .ecc_interrupt        (ecc_interrupt),
    .err_addr             (err_addr),
    .err_addr_fatal       (err_addr_fatal),
    .corr_err_count       (corr_err_count),
    .fatal_err_count      (fatal_err_count),
    .scrub_drop_count     (scrub_drop_count)
  );

  initial ctl_clk = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  typedef struct {
    logic          en_ecc;
    logic          auto_corr;
    logic          c;
    logic          d;
    logic          f;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_int;
    logic [CW-1:0] exp_corr;
    logic [CW-1:0] exp_fatal;
    logic          exp_req;
    logic          chk_addr;
    logic          exp_afatal;
  } vec_t;

  vec_t vecs[6];

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_status(input logic c, input logic d, input logic f, input logic [DW-1:0] data);
    dec_err_corrected = c;
    dec_err_detected  = d;
    dec_err_fatal     = f;
    dec_data          = data;
  endtask

  // Returns to a clean state: counters and interrupt cleared, any pending scrub acknowledged.
  task automatic clean();
    cfg_clr_cnt  = 1'b1;
    cfg_clr_intr = 1'b1;
    scrub_ack    = 1'b1;
    tick();
    cfg_clr_cnt  = 1'b0;
    cfg_clr_intr = 1'b0;
    scrub_ack    = 1'b0;
  endtask

  // One beat at cycle t with status at t+1; returns at t+2.
  task automatic beat(input logic [AW-1:0] addr, input logic c, input logic d, input logic f,
                      input logic [DW-1:0] data);
    rdata_valid = 1'b1;
    rdata_addr  = addr;
    tick();
    rdata_valid = 1'b0;
    set_status(c, d, f, data);
    tick();
    set_status(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    ctl_reset_n          = 1'b0;
    cfg_enable_ecc       = 1'b1;
    cfg_enable_auto_corr = 1'b1;
    cfg_clr_intr         = 1'b0;
    cfg_clr_cnt          = 1'b0;
    rdata_valid          = 1'b0;
    rdata_addr           = '0;
    scrub_ack            = 1'b0;
    set_status(1'b0, 1'b0, 1'b0, '0);

    //        en auto c  d  f  addr        data                   int corr fat req chk afat
    vecs[0] = '{1, 1, 1, 1, 0, 24'h000123, 64'hDEAD_BEEF_0000_0001, 1, 1, 0, 1, 1, 0};
    vecs[1] = '{1, 1, 0, 1, 1, 24'h000456, 64'h0,                   1, 0, 1, 0, 1, 1};
    vecs[2] = '{1, 1, 0, 1, 0, 24'h000789, 64'h0,                   1, 0, 0, 0, 0, 0};
    vecs[3] = '{0, 1, 1, 1, 0, 24'h000AAA, 64'h1234,                0, 0, 0, 0, 0, 0};
    vecs[4] = '{1, 1, 1, 1, 1, 24'h000BBB, 64'h5555,                1, 0, 1, 0, 1, 1};
    vecs[5] = '{1, 0, 1, 0, 0, 24'h000CCC, 64'h7777,                0, 1, 0, 0, 1, 0};

    repeat (3) tick();
    check("rst_req", 64'(scrub_req), 64'd0);
    check("rst_int", 64'(ecc_interrupt), 64'd0);
    check("rst_corr", 64'(corr_err_count), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    ctl_reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      clean();
      cfg_enable_ecc       = vecs[i].en_ecc;
      cfg_enable_auto_corr = vecs[i].auto_corr;
      beat(vecs[i].addr, vecs[i].c, vecs[i].d, vecs[i].f, vecs[i].data);
      $display("vec %0d addr=%0h c=%0b d=%0b f=%0b en=%0b -> int=%0b corr=%0d fat=%0d req=%0b",
               i, vecs[i].addr, vecs[i].c, vecs[i].d, vecs[i].f, vecs[i].en_ecc,
               ecc_interrupt, corr_err_count, fatal_err_count, scrub_req);
      check($sformatf("v%0d_int", i), 64'(ecc_interrupt), 64'(vecs[i].exp_int));
      check($sformatf("v%0d_corr", i), 64'(corr_err_count), 64'(vecs[i].exp_corr));
      check($sformatf("v%0d_fatal", i), 64'(fatal_err_count), 64'(vecs[i].exp_fatal));
      check($sformatf("v%0d_req", i), 64'(scrub_req), 64'(vecs[i].exp_req));
      if (vecs[i].chk_addr) begin
        check($sformatf("v%0d_err_addr", i), 64'(err_addr), 64'(vecs[i].addr));
        check($sformatf("v%0d_afatal", i), 64'(err_addr_fatal), 64'(vecs[i].exp_afatal));
      end
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_scrub_data", i), scrub_data, vecs[i].data);
      end
    end
    cfg_enable_ecc       = 1'b1;
    cfg_enable_auto_corr = 1'b1;

    // Single beat, ack at t+4, request gone at t+5.
    clean();
    beat(24'h000123, 1'b1, 1'b1, 1'b0, 64'hCAFE_F00D_1234_5678);
    $display("seq single: req=%0b addr=%0h data=%0h", scrub_req, scrub_addr, scrub_data);
    check("s1_req_t2", 64'(scrub_req), 64'd1);
    check("s1_addr", 64'(scrub_addr), 64'h123);
    check("s1_data", scrub_data, 64'hCAFE_F00D_1234_5678);
    check("s1_err_addr", 64'(err_addr), 64'h123);
    tick();
    check("s1_req_t3", 64'(scrub_req), 64'd1);
    tick();
    scrub_ack = 1'b1;
    tick();
    scrub_ack = 1'b0;
    check("s1_req_t5", 64'(scrub_req), 64'd0);

    // Two back-to-back corrected beats while the first request waits for a late ack.
    clean();
    rdata_valid = 1'b1; rdata_addr = 24'h000200;
    tick();
    rdata_addr = 24'h000208;
    set_status(1'b1, 1'b0, 1'b0, 64'h1111);
    tick();
    rdata_valid = 1'b0;
    set_status(1'b1, 1'b0, 1'b0, 64'h2222);
    tick();
    set_status(1'b0, 1'b0, 1'b0, '0);
    $display("seq drop: corr=%0d drop=%0d addr=%0h", corr_err_count, scrub_drop_count, scrub_addr);
    check("s2_corr", 64'(corr_err_count), 64'd2);
    check("s2_drop", 64'(scrub_drop_count), 64'd1);
    check("s2_addr", 64'(scrub_addr), 64'h200);
    check("s2_data", scrub_data, 64'h1111);
    repeat (4) tick();
    check("s2_hold_req", 64'(scrub_req), 64'd1);
    scrub_ack = 1'b1;
    tick();
    scrub_ack = 1'b0;
    check("s2_req_done", 64'(scrub_req), 64'd0);

    // C then two F: the first F replaces the C capture, the second F does not.
    clean();
    rdata_valid = 1'b1; rdata_addr = 24'h000010;
    tick();
    rdata_addr = 24'h000020;
    set_status(1'b1, 1'b1, 1'b0, 64'hAAAA);
    tick();
    rdata_addr = 24'h000030;
    set_status(1'b0, 1'b1, 1'b1, 64'hBBBB);
    tick();
    rdata_valid = 1'b0;
    set_status(1'b0, 1'b1, 1'b1, 64'hCCCC);
    tick();
    set_status(1'b0, 1'b0, 1'b0, '0);
    $display("seq fatal: err_addr=%0h afatal=%0b fat=%0d", err_addr, err_addr_fatal, fatal_err_count);
    check("s3_err_addr", 64'(err_addr), 64'h20);
    check("s3_afatal", 64'(err_addr_fatal), 64'd1);
    check("s3_fatal", 64'(fatal_err_count), 64'd2);
    check("s3_corr", 64'(corr_err_count), 64'd1);
    check("s3_scrub_addr", 64'(scrub_addr), 64'h10);
    check("s3_scrub_data", scrub_data, 64'hAAAA);

    // Saturation: 300 corrected events, then clear coinciding with an event.
    clean();
    cfg_enable_auto_corr = 1'b0;
    rdata_valid = 1'b1;
    tick();
    for (int i = 1; i < 300; i++) begin
      rdata_addr = AW'(i);
      set_status(1'b1, 1'b0, 1'b0, '0);
      tick();
    end
    rdata_valid = 1'b0;
    tick();
    set_status(1'b0, 1'b0, 1'b0, '0);
    tick();
    $display("seq sat: corr=%0d", corr_err_count);
    check("s4_sat", 64'(corr_err_count), 64'd255);
    rdata_valid = 1'b1;
    tick();
    rdata_valid = 1'b0;
    set_status(1'b1, 1'b0, 1'b0, '0);
    cfg_clr_cnt = 1'b1;
    tick();
    cfg_clr_cnt = 1'b0;
    set_status(1'b0, 1'b0, 1'b0, '0);
    check("s4_clr_inc", 64'(corr_err_count), 64'd1);
    cfg_enable_auto_corr = 1'b1;

    // Interrupt clear coinciding with a new detected error.
    clean();
    beat(24'h000040, 1'b1, 1'b1, 1'b0, 64'h40);
    check("s5_first_addr", 64'(err_addr), 64'h40);
    rdata_valid = 1'b1; rdata_addr = 24'h000050;
    tick();
    rdata_valid = 1'b0;
    set_status(1'b1, 1'b1, 1'b0, 64'h50);
    cfg_clr_intr = 1'b1;
    tick();
    cfg_clr_intr = 1'b0;
    set_status(1'b0, 1'b0, 1'b0, '0);
    $display("seq clr_intr: int=%0b err_addr=%0h", ecc_interrupt, err_addr);
    check("s5_int_kept", 64'(ecc_interrupt), 64'd1);
    check("s5_new_addr", 64'(err_addr), 64'h50);
    cfg_clr_intr = 1'b1;
    tick();
    cfg_clr_intr = 1'b0;
    check("s5_int_clr", 64'(ecc_interrupt), 64'd0);

    // Reset asserted mid-request drops it immediately; a later event scrubs normally.
    clean();
    beat(24'h000060, 1'b1, 1'b1, 1'b0, 64'h60);
    check("s6_req_before", 64'(scrub_req), 64'd1);
    ctl_reset_n = 1'b0;
    #2;
    $display("seq reset: req=%0b corr=%0d", scrub_req, corr_err_count);
    check("s6_req_rst", 64'(scrub_req), 64'd0);
    check("s6_corr_rst", 64'(corr_err_count), 64'd0);
    check("s6_int_rst", 64'(ecc_interrupt), 64'd0);
    tick();
    ctl_reset_n = 1'b1;
    tick();
    check("s6_no_retry", 64'(scrub_req), 64'd0);
    beat(24'h000070, 1'b1, 1'b0, 1'b0, 64'h70);
    check("s6_req_after", 64'(scrub_req), 64'd1);
    check("s6_addr_after", 64'(scrub_addr), 64'h70);
    check("s6_corr_after", 64'(corr_err_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
